// File: rtl/sink_a_multibeat.sv
// sink_a_multibeat: A-channel ingress for the L2 cache.
// First beat of each transaction produces one scheduler request; every data
// beat is parked in an indexed put buffer that the scheduler pops beat by beat.
// Optional feature macro: SINKA_REQ_REG_EN (registered request output stage).
module sink_a_multibeat #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int SOURCE_W  = 8,
    parameter int SET_W     = 6,
    parameter int OFFSET_W  = 4,
    parameter int SIZE_W    = 3,
    parameter int OP_W      = 3,
    parameter int PARAM_W   = 3,
    parameter int PUT_LISTS = 4,
    parameter int MAX_BEATS = 4,
    localparam int MASK_W   = DATA_W / 8,
    localparam int TAG_W    = ADDR_W - SET_W - OFFSET_W,
    localparam int PUT_W    = $clog2(PUT_LISTS),
    localparam int BEAT_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [OP_W-1:0]     a_opcode,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [MASK_W-1:0]   a_mask,
    input  logic [DATA_W-1:0]   a_data,
    input  logic [PARAM_W-1:0]  a_param,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [OP_W-1:0]     req_opcode,
    output logic [SIZE_W-1:0]   req_size,
    output logic [SOURCE_W-1:0] req_source,
    output logic [PARAM_W-1:0]  req_param,
    output logic [TAG_W-1:0]    req_tag,
    output logic [SET_W-1:0]    req_set,
    output logic [OFFSET_W-1:0] req_offset,
    output logic [PUT_W-1:0]    req_put,
    output logic [BEAT_W:0]     req_beats,
    input  logic                invalidate_ready,
    input  logic                flush_ready,
    input  logic                pb_pop_valid,
    output logic                pb_pop_ready,
    input  logic [PUT_W-1:0]    pb_pop_index,
    output logic [DATA_W-1:0]   pb_beat_data,
    output logic [MASK_W-1:0]   pb_beat_mask,
    output logic                pb_last,
    output logic                empty
);

    localparam int CNT_W = BEAT_W + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state;
    logic [PUT_W-1:0]     burst_put;
    logic [PUT_LISTS-1:0] busy;
    logic [CNT_W-1:0]     wr_cnt [PUT_LISTS];
    logic [CNT_W-1:0]     rd_cnt [PUT_LISTS];
    logic [CNT_W-1:0]     total  [PUT_LISTS];
    logic [DATA_W-1:0]    buf_data [PUT_LISTS][MAX_BEATS];
    logic [MASK_W-1:0]    buf_mask [PUT_LISTS][MAX_BEATS];

    logic                 is_data;
    logic                 hint_ok;
    logic                 free;
    logic                 slot_ok;
    logic                 first_ok;
    logic                 first_fire;
    logic                 burst_fire;
    logic                 burst_last;
    logic                 pop_fire;
    logic                 pop_done;
    logic [PUT_W-1:0]     alloc_idx;
    logic [CNT_W-1:0]     beats;
    logic [31:0]          beat_bytes;
    logic [31:0]          beat_q;
    logic [CNT_W-1:0]     pop_rd;

    assign is_data = (a_opcode == OP_W'(0)) || (a_opcode == OP_W'(1));
    // Hint (opcode 5) waits for the matching downstream ready: invalidate on param 1, flush otherwise.
    assign hint_ok = (a_opcode != OP_W'(5)) ||
                     ((a_param == PARAM_W'(1)) ? invalidate_ready : flush_ready);
    assign free    = ~&busy;

    // Lowest-index free list, from registered busy only.
    always_comb begin
        alloc_idx = '0;
        for (int i = PUT_LISTS - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_idx = PUT_W'(i);
        end
    end

    // Beat count of the incoming transaction, clamped to [1, MAX_BEATS].
    always_comb begin
        beat_bytes = 32'd1 << a_size;
        beat_q     = beat_bytes / 32'(MASK_W);
        if (beat_q == 32'd0) beat_q = 32'd1;
        if (beat_q > 32'(MAX_BEATS)) beat_q = 32'(MAX_BEATS);
        beats = CNT_W'(beat_q);
    end

    assign first_ok   = slot_ok && hint_ok && (!is_data || free);
    assign a_ready    = !rst && ((state == BURST) || first_ok);
    assign first_fire = a_valid && a_ready && (state == IDLE);
    assign burst_fire = a_valid && a_ready && (state == BURST);
    assign burst_last = (wr_cnt[burst_put] + CNT_W'(1)) == total[burst_put];

    assign pop_rd       = rd_cnt[pb_pop_index];
    assign pb_pop_ready = !rst && busy[pb_pop_index] && (pop_rd < wr_cnt[pb_pop_index]);
    assign pb_beat_data = buf_data[pb_pop_index][pop_rd[BEAT_W-1:0]];
    assign pb_beat_mask = buf_mask[pb_pop_index][pop_rd[BEAT_W-1:0]];
    assign pop_done     = (pop_rd + CNT_W'(1)) == total[pb_pop_index];
    assign pb_last      = pb_pop_ready && pop_done;
    assign pop_fire     = pb_pop_valid && pb_pop_ready;

    assign empty = rst || (!(|busy) && (state == IDLE));

    // Receive FSM plus per-list bookkeeping. An allocating list is never busy
    // and a popped list always is, so allocate and pop never hit the same list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            burst_put <= '0;
            busy      <= '0;
            for (int i = 0; i < PUT_LISTS; i++) begin
                wr_cnt[i] <= '0;
                rd_cnt[i] <= '0;
                total[i]  <= '0;
            end
        end else begin
            if (first_fire && is_data) begin
                busy[alloc_idx]   <= 1'b1;
                wr_cnt[alloc_idx] <= CNT_W'(1);
                rd_cnt[alloc_idx] <= '0;
                total[alloc_idx]  <= beats;
                if (beats > CNT_W'(1)) begin
                    state     <= BURST;
                    burst_put <= alloc_idx;
                end
            end
            if (burst_fire) begin
                wr_cnt[burst_put] <= wr_cnt[burst_put] + CNT_W'(1);
                if (burst_last) state <= IDLE;
            end
            if (pop_fire) begin
                if (pop_done) begin
                    busy[pb_pop_index]   <= 1'b0;
                    wr_cnt[pb_pop_index] <= '0;
                    rd_cnt[pb_pop_index] <= '0;
                    total[pb_pop_index]  <= '0;
                end else begin
                    rd_cnt[pb_pop_index] <= pop_rd + CNT_W'(1);
                end
            end
        end
    end

    // Put buffer storage; contents need no reset because the counters gate every read.
    always_ff @(posedge clk) begin
        if (first_fire && is_data) begin
            buf_data[alloc_idx][0] <= a_data;
            buf_mask[alloc_idx][0] <= a_mask;
        end
        if (burst_fire) begin
            buf_data[burst_put][wr_cnt[burst_put][BEAT_W-1:0]] <= a_data;
            buf_mask[burst_put][wr_cnt[burst_put][BEAT_W-1:0]] <= a_mask;
        end
    end

    logic [PUT_W-1:0] nxt_put;
    assign nxt_put = is_data ? alloc_idx : '0;

`ifdef SINKA_REQ_REG_EN
    logic                rq_valid;
    logic [OP_W-1:0]     rq_opcode;
    logic [SIZE_W-1:0]   rq_size;
    logic [SOURCE_W-1:0] rq_source;
    logic [PARAM_W-1:0]  rq_param;
    logic [ADDR_W-1:0]   rq_address;
    logic [PUT_W-1:0]    rq_put;
    logic [CNT_W-1:0]    rq_beats;

    assign slot_ok = !rq_valid || req_ready;

    // One-entry request register: loads on first-beat acceptance, drains on req_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            rq_valid <= 1'b0;
        end else if (first_fire) begin
            rq_valid <= 1'b1;
        end else if (req_ready) begin
            rq_valid <= 1'b0;
        end
        if (first_fire) begin
            rq_opcode  <= a_opcode;
            rq_size    <= a_size;
            rq_source  <= a_source;
            rq_param   <= a_param;
            rq_address <= a_address;
            rq_put     <= nxt_put;
            rq_beats   <= beats;
        end
    end

    assign req_valid  = rq_valid && !rst;
    assign req_opcode = rq_opcode;
    assign req_size   = rq_size;
    assign req_source = rq_source;
    assign req_param  = rq_param;
    assign req_tag    = rq_address[ADDR_W-1 -: TAG_W];
    assign req_set    = rq_address[OFFSET_W +: SET_W];
    assign req_offset = rq_address[OFFSET_W-1:0];
    assign req_put    = rq_put;
    assign req_beats  = rq_beats;
`else
    assign slot_ok    = req_ready;
    assign req_valid  = !rst && (state == IDLE) && a_valid && first_ok;
    assign req_opcode = a_opcode;
    assign req_size   = a_size;
    assign req_source = a_source;
    assign req_param  = a_param;
    assign req_tag    = a_address[ADDR_W-1 -: TAG_W];
    assign req_set    = a_address[OFFSET_W +: SET_W];
    assign req_offset = a_address[OFFSET_W-1:0];
    assign req_put    = nxt_put;
    assign req_beats  = beats;
`endif

endmodule

// File: tb/tb_sink_a_multibeat.sv
// Self-checking bench for sink_a_multibeat (default, combinational request path).
module tb_sink_a_multibeat;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_size = '0;
    logic [7:0]  a_source = '0;
    logic [31:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic [2:0]  a_param = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [2:0]  req_opcode, req_size, req_param;
    logic [7:0]  req_source;
    logic [21:0] req_tag;
    logic [5:0]  req_set;
    logic [3:0]  req_offset;
    logic [1:0]  req_put;
    logic [2:0]  req_beats;
    logic        invalidate_ready = 1'b0;
    logic        flush_ready = 1'b0;
    logic        pb_pop_valid = 1'b0;
    logic        pb_pop_ready;
    logic [1:0]  pb_pop_index = '0;
    logic [63:0] pb_beat_data;
    logic [7:0]  pb_beat_mask;
    logic        pb_last;
    logic        empty;

    sink_a_multibeat dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_opcode(a_opcode), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_param(a_param),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_size(req_size), .req_source(req_source),
        .req_param(req_param), .req_tag(req_tag), .req_set(req_set),
        .req_offset(req_offset), .req_put(req_put), .req_beats(req_beats),
        .invalidate_ready(invalidate_ready), .flush_ready(flush_ready),
        .pb_pop_valid(pb_pop_valid), .pb_pop_ready(pb_pop_ready),
        .pb_pop_index(pb_pop_index), .pb_beat_data(pb_beat_data),
        .pb_beat_mask(pb_beat_mask), .pb_last(pb_last), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [7:0]  src;
        logic [2:0]  param;
        logic [21:0] tag;
        logic [5:0]  set;
        logic [3:0]  off;
        logic [1:0]  put;
        logic [2:0]  beats;
    } req_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  mask;
        logic        last;
    } beat_t;

    req_t  req_q[$];
    beat_t pq[4][$];
    logic [3:0] mbusy = '0;
    int compared = 0;
    int mismatched = 0;

    function automatic logic [2:0] model_beats(input logic [2:0] sz);
        int b;
        b = (1 << sz) / 8;
        if (b < 1) b = 1;
        if (b > 4) b = 4;
        return 3'(b);
    endfunction

    function automatic logic [1:0] model_alloc(input logic [3:0] bsy);
        for (int i = 0; i < 4; i++) if (!bsy[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic req_t mk_req(input logic [2:0] op, sz, input logic [7:0] src,
                                    input logic [2:0] prm, input logic [31:0] addr,
                                    input logic [1:0] put);
        req_t r;
        r.op = op; r.size = sz; r.src = src; r.param = prm;
        r.tag = addr[31:10]; r.set = addr[9:4]; r.off = addr[3:0];
        r.put = put; r.beats = model_beats(sz);
        return r;
    endfunction

    // Drive one beat until accepted (bounded); report what the DUT showed in the accept cycle.
    task automatic drive_beat(input logic [2:0] op, sz, input logic [7:0] src,
                              input logic [31:0] addr, input logic [63:0] data,
                              input logic [7:0] mask, input logic [2:0] prm,
                              output logic acc, output logic gotreq, output req_t obs,
                              output logic emp, output int waited);
        a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
        a_address = addr; a_data = data; a_mask = mask; a_param = prm;
        acc = 1'b0; gotreq = 1'b0; obs = '0; emp = 1'b0; waited = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (a_ready === 1'b1) begin
                acc = 1'b1;
                gotreq = req_valid & req_ready;
                obs = {req_opcode, req_size, req_source, req_param, req_tag,
                       req_set, req_offset, req_put, req_beats};
                emp = empty;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
    endtask

    // Pop one beat from list idx (bounded wait); report observed beat.
    task automatic do_pop(input logic [1:0] idx, output logic acc, output beat_t obs);
        pb_pop_valid = 1'b1; pb_pop_index = idx; acc = 1'b0; obs = '0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (pb_pop_ready === 1'b1) begin
                acc = 1'b1;
                obs = {pb_beat_data, pb_beat_mask, pb_last};
            end
            @(posedge clk); #1;
        end
        pb_pop_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_ready = 1'b1; a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd3;
        pb_pop_valid = 1'b1; pb_pop_index = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++; if (a_ready !== 1'b0) begin mismatched++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
        compared++; if (req_valid !== 1'b0) begin mismatched++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
        compared++; if (pb_pop_ready !== 1'b0) begin mismatched++; $display("FAIL reset_pop_ready got=%b exp=0", pb_pop_ready); end
        compared++; if (pb_last !== 1'b0) begin mismatched++; $display("FAIL reset_pb_last got=%b exp=0", pb_last); end
        compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty got=%b exp=1", empty); end
        @(posedge clk); #1;
        rst = 1'b0; a_valid = 1'b0; pb_pop_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_get;
        logic acc, gr, emp; req_t obs, exp; int w;
        req_q.push_back(mk_req(3'd4, 3'd3, 8'h11, 3'd0, 32'h1234_5670, 2'd0));
        drive_beat(3'd4, 3'd3, 8'h11, 32'h1234_5670, 64'h0, 8'h0, 3'd0, acc, gr, obs, emp, w);
        compared++; if (acc !== 1'b1) begin mismatched++; $display("FAIL get_accept got=%b exp=1", acc); end
        compared++; if (gr !== 1'b1) begin mismatched++; $display("FAIL get_req_valid got=%b exp=1", gr); end
        compared++; if (emp !== 1'b1) begin mismatched++; $display("FAIL get_empty got=%b exp=1", emp); end
        exp = req_q.pop_front();
        compared++; if (obs !== exp) begin mismatched++; $display("FAIL get_fields got=%h exp=%h", obs, exp); end
        @(negedge clk);
        compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL get_empty_after got=%b exp=1", empty); end
        @(posedge clk); #1;
    endtask

    task automatic test_burst;
        logic acc, gr, emp; req_t obs, exp; beat_t bo, be; int w; logic [63:0] d;
        req_q.push_back(mk_req(3'd0, 3'd5, 8'h22, 3'd0, 32'h0000_4440, model_alloc(mbusy)));
        for (int k = 0; k < 4; k++) pq[0].push_back({64'hA0A0_0000_0000_0000 + 64'(k), 8'hFF, k == 3});
        mbusy[0] = 1'b1;
        drive_beat(3'd0, 3'd5, 8'h22, 32'h0000_4440, 64'hA0A0_0000_0000_0000, 8'hFF, 3'd0, acc, gr, obs, emp, w);
        compared++; if (gr !== 1'b1) begin mismatched++; $display("FAIL burst_first_req got=%b exp=1", gr); end
        exp = req_q.pop_front();
        compared++; if (obs !== exp) begin mismatched++; $display("FAIL burst_fields got=%h exp=%h", obs, exp); end
        req_ready = 1'b0;
        for (int k = 1; k < 4; k++) begin
            d = 64'hA0A0_0000_0000_0000 + 64'(k);
            drive_beat(3'd4, 3'd5, 8'h22, 32'h0, d, 8'hFF, 3'd0, acc, gr, obs, emp, w);
            compared++; if (w !== 0) begin mismatched++; $display("FAIL burst_beat%0d_wait got=%0d exp=0", k, w); end
            compared++; if (gr !== 1'b0) begin mismatched++; $display("FAIL burst_beat%0d_req got=%b exp=0", k, gr); end
            compared++; if (emp !== 1'b0) begin mismatched++; $display("FAIL burst_beat%0d_empty got=%b exp=0", k, emp); end
        end
        req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_pop(2'd0, acc, bo);
            be = pq[0].pop_front();
            compared++; if (acc !== 1'b1 || bo !== be) begin mismatched++; $display("FAIL burst_pop%0d got=%h exp=%h", k, bo, be); end
        end
        mbusy[0] = 1'b0;
        @(negedge clk);
        compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL burst_empty_end got=%b exp=1", empty); end
        @(posedge clk); #1;
    endtask

    task automatic test_full;
        logic acc, gr, emp; req_t obs, exp; beat_t bo, be; int w; logic [1:0] p; logic [63:0] d;
        for (int i = 0; i < 4; i++) begin
            p = model_alloc(mbusy); d = 64'hD000 + 64'(i);
            req_q.push_back(mk_req(3'd1, 3'd3, 8'h30 + 8'(i), 3'd0, 32'h100 * i, p));
            pq[p].push_back({d, 8'h0F, 1'b1});
            mbusy[p] = 1'b1;
            drive_beat(3'd1, 3'd3, 8'h30 + 8'(i), 32'h100 * i, d, 8'h0F, 3'd0, acc, gr, obs, emp, w);
            exp = req_q.pop_front();
            compared++; if (gr !== 1'b1 || obs !== exp) begin mismatched++; $display("FAIL full_fill%0d got=%h exp=%h", i, obs, exp); end
        end
        a_valid = 1'b1; a_opcode = 3'd0; a_size = 3'd3; a_data = 64'hBAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++; if (a_ready !== 1'b0) begin mismatched++; $display("FAIL full_stall%0d got=%b exp=0", i, a_ready); end
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        req_q.push_back(mk_req(3'd4, 3'd3, 8'h44, 3'd0, 32'hABC0, 2'd0));
        drive_beat(3'd4, 3'd3, 8'h44, 32'hABC0, 64'h0, 8'h0, 3'd0, acc, gr, obs, emp, w);
        exp = req_q.pop_front();
        compared++; if (acc !== 1'b1 || w !== 0 || obs !== exp) begin mismatched++; $display("FAIL full_get_pass got=%h exp=%h waited=%0d", obs, exp, w); end
        do_pop(2'd2, acc, bo);
        be = pq[2].pop_front();
        compared++; if (acc !== 1'b1 || bo !== be) begin mismatched++; $display("FAIL full_pop2 got=%h exp=%h", bo, be); end
        mbusy[2] = 1'b0;
        p = model_alloc(mbusy); d = 64'hE222;
        req_q.push_back(mk_req(3'd0, 3'd3, 8'h55, 3'd0, 32'h2000, p));
        pq[p].push_back({d, 8'hF0, 1'b1});
        mbusy[p] = 1'b1;
        drive_beat(3'd0, 3'd3, 8'h55, 32'h2000, d, 8'hF0, 3'd0, acc, gr, obs, emp, w);
        exp = req_q.pop_front();
        compared++; if (w !== 0 || gr !== 1'b1 || obs !== exp) begin mismatched++; $display("FAIL full_realloc got=%h exp=%h waited=%0d", obs, exp, w); end
        for (int i = 0; i < 4; i++) begin
            do_pop(2'(i), acc, bo);
            be = pq[i].pop_front();
            compared++; if (acc !== 1'b1 || bo !== be) begin mismatched++; $display("FAIL full_drain%0d got=%h exp=%h", i, bo, be); end
            mbusy[i] = 1'b0;
        end
        @(negedge clk);
        compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL full_empty_end got=%b exp=1", empty); end
        @(posedge clk); #1;
    endtask

    task automatic test_hint;
        logic acc, gr, emp; req_t obs, exp; int w;
        invalidate_ready = 1'b0; flush_ready = 1'b1;
        a_valid = 1'b1; a_opcode = 3'd5; a_param = 3'd1; a_size = 3'd3; a_address = 32'h7770; a_source = 8'h66;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++; if (a_ready !== 1'b0 || req_valid !== 1'b0) begin mismatched++; $display("FAIL hint_block%0d got=%b%b exp=00", i, a_ready, req_valid); end
            @(posedge clk); #1;
        end
        invalidate_ready = 1'b1;
        req_q.push_back(mk_req(3'd5, 3'd3, 8'h66, 3'd1, 32'h7770, 2'd0));
        drive_beat(3'd5, 3'd3, 8'h66, 32'h7770, 64'h0, 8'h0, 3'd1, acc, gr, obs, emp, w);
        exp = req_q.pop_front();
        compared++; if (w !== 0 || gr !== 1'b1 || obs !== exp) begin mismatched++; $display("FAIL hint_accept got=%h exp=%h waited=%0d", obs, exp, w); end
        invalidate_ready = 1'b0; flush_ready = 1'b0;
    endtask

    task automatic test_pop_timing;
        beat_t bo, be;
        pb_pop_index = 2'd0; pb_pop_valid = 1'b1;
        a_valid = 1'b1; a_opcode = 3'd0; a_size = 3'd2; a_data = 64'h1357_9BDF; a_mask = 8'h3C; a_address = 32'h40;
        pq[0].push_back({64'h1357_9BDF, 8'h3C, 1'b1});
        mbusy[0] = 1'b1;
        @(negedge clk);
        compared++; if (a_ready !== 1'b1) begin mismatched++; $display("FAIL popt_accept got=%b exp=1", a_ready); end
        compared++; if (pb_pop_ready !== 1'b0) begin mismatched++; $display("FAIL popt_same_cycle got=%b exp=0", pb_pop_ready); end
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        bo = {pb_beat_data, pb_beat_mask, pb_last};
        be = pq[0].pop_front();
        compared++; if (pb_pop_ready !== 1'b1) begin mismatched++; $display("FAIL popt_next_cycle got=%b exp=1", pb_pop_ready); end
        compared++; if (bo !== be) begin mismatched++; $display("FAIL popt_data got=%h exp=%h", bo, be); end
        @(posedge clk); #1;
        pb_pop_valid = 1'b0;
        mbusy[0] = 1'b0;
    endtask

    task automatic test_reset_burst;
        logic acc, gr, emp; req_t obs, exp; beat_t bo, be; int w;
        req_q.push_back(mk_req(3'd0, 3'd5, 8'h77, 3'd0, 32'h9990, 2'd0));
        drive_beat(3'd0, 3'd5, 8'h77, 32'h9990, 64'hF0, 8'hFF, 3'd0, acc, gr, obs, emp, w);
        exp = req_q.pop_front();
        compared++; if (obs !== exp) begin mismatched++; $display("FAIL rstb_first got=%h exp=%h", obs, exp); end
        drive_beat(3'd0, 3'd5, 8'h77, 32'h0, 64'hF1, 8'hFF, 3'd0, acc, gr, obs, emp, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mbusy = '0;
        pb_pop_index = 2'd0;
        @(negedge clk);
        compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL rstb_empty got=%b exp=1", empty); end
        compared++; if (pb_pop_ready !== 1'b0) begin mismatched++; $display("FAIL rstb_discard got=%b exp=0", pb_pop_ready); end
        @(posedge clk); #1;
        req_q.push_back(mk_req(3'd1, 3'd3, 8'h78, 3'd0, 32'h5550, model_alloc(mbusy)));
        pq[0].push_back({64'hC0DE, 8'h81, 1'b1});
        mbusy[0] = 1'b1;
        drive_beat(3'd1, 3'd3, 8'h78, 32'h5550, 64'hC0DE, 8'h81, 3'd0, acc, gr, obs, emp, w);
        exp = req_q.pop_front();
        compared++; if (gr !== 1'b1 || obs !== exp) begin mismatched++; $display("FAIL rstb_realloc got=%h exp=%h req=%b", obs, exp, gr); end
        do_pop(2'd0, acc, bo);
        be = pq[0].pop_front();
        compared++; if (acc !== 1'b1 || bo !== be) begin mismatched++; $display("FAIL rstb_pop got=%h exp=%h", bo, be); end
        mbusy[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_get();
        test_burst();
        test_full();
        test_hint();
        test_pop_timing();
        test_reset_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", compared);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sink_a_multibeat.md
# sink_a_multibeat

Parametrised A-channel ingress for the L2 cache and successor to the single-beat sink. It accepts TileLink-lite A beats from L1, including multi-beat PutFull/PutPartial bursts. It splits each transaction into a single scheduler request plus per-beat payload held in an indexed put buffer, and it gates flush/invalidate hints on the matching L2 ready. The scheduler pops payload beat by beat; a put-list slot is released on the last popped beat.

## Interface
Parameters:
- ADDR_W, 32, A address width
- DATA_W, 64, beat data width; MASK_W = DATA_W/8
- SOURCE_W, 8, source ID width
- SET_W, 6, set index width
- OFFSET_W, 4, byte offset width; TAG_W = ADDR_W-SET_W-OFFSET_W
- SIZE_W / OP_W / PARAM_W, 3 / 3 / 3, field widths
- PUT_LISTS, 4, concurrent put transactions, ≥2; PUT_W = $clog2(PUT_LISTS)
- MAX_BEATS, 4, beats per put buffered, power of 2; BEAT_W = max(1,$clog2(MAX_BEATS))

Ports:
- clk in 1: clock
- rst in 1: synchronous, active-high reset
- a_valid / a_ready: in 1 / out 1: A beat handshake
- a_opcode, a_size, a_source, a_address, a_mask, a_data, a_param: in, field widths: A beat fields
- req_valid / req_ready: out 1 / in 1: scheduler request handshake
- req_opcode, req_size, req_source, req_param: out, field widths: copied from the first beat
- req_tag / req_set / req_offset: out, TAG_W / SET_W / OFFSET_W: address split, with tag as the MSBs and offset as the LSBs
- req_put: out PUT_W: allocated list index; 0 for non-data ops
- req_beats: out BEAT_W+1: beat count of the transaction
- invalidate_ready / flush_ready: in 1: downstream readiness for opcode 5 with param==1 and param!=1 respectively
- pb_pop_valid / pb_pop_ready: in 1 / out 1: payload pop handshake
- pb_pop_index: in PUT_W: list to pop
- pb_beat_data / pb_beat_mask: out DATA_W / MASK_W: head beat of the selected list, combinational
- pb_last: out 1: the popped beat is the final beat of its list
- empty: out 1: no list busy and no burst in progress

## Operation
- Data opcodes are 0 and 1. Beat count = max(1, (1<<a_size)/MASK_W), saturated at MAX_BEATS.
- Per-list registered state: `busy`, `wr_cnt` (BEAT_W+1), `rd_cnt` (BEAT_W+1), `total`.
- The receive FSM has two states:
  - IDLE, first-beat acceptance:
    - Non-data op: a_ready = req_ready.
    - Data op: a_ready = req_ready & free.
    - Opcode 5: additionally requires invalidate_ready (param==1) or flush_ready (param!=1).
    - req_valid uses the same gate with a_valid.
  - BURST: transaction beats 2..N. a_ready=1 unconditionally, because the slot is reserved. No request is issued. Beat k is written to [put][k].
- Transitions: IDLE→BURST on an accepted data first beat with beats>1. BURST→IDLE on the accepted last beat.
- Allocation: `free` = ~&busy. On first-beat acceptance, the lowest-index free list is set busy, with wr_cnt=1 and total=beats.
- pb_pop_ready = busy[idx] & (rd_cnt[idx] < wr_cnt[idx]). Data/mask are read at [idx][rd_cnt]. Each pop increments rd_cnt.
- When rd_cnt reaches total, the pop clears busy and zeroes the counters.
- Any opcode seen during BURST is treated as a continuation beat.

## Timing
- Reset values:
  - busy=0, counters=0, FSM=IDLE.
  - req_valid=0, pb_pop_ready=0, pb_last=0, empty=1, a_ready=0 while rst is high.
- Request latency is 0 cycles (combinational) from the first beat, unless the config macro below is set.
- A beat written in cycle t is poppable from t+1; there is no write-to-read bypass.
- A list freed by a pop in cycle t is allocatable from t+1. The free vector uses registered `busy`.
- Allocate and pop on different lists in the same cycle are both honoured.
- Full: all lists busy → data first beats stall (a_ready=0). Non-data ops still pass.
- Reset asserted mid-burst discards all buffered beats and returns the FSM to IDLE.

## Configuration
- SINKA_REQ_REG_EN defined:
  - Request fields pass through a one-entry output register.
  - req_valid appears 1 cycle after first-beat acceptance.
  - The first beat is accepted when the register is empty or draining (req_ready) in the same cycle.
  - List allocation still occurs at acceptance.
- SINKA_REQ_REG_EN undefined: fully combinational request path, as described above.

## Test plan
- Get (op4), size 3, address 0x1234_5670, req_ready=1 → same-cycle req_valid; tag/set/offset split correctly; req_put=0; empty stays 1.
- PutFull, size 5, MASK_W=8 (4 beats): data A0..A3, list 0 free → one request with put=0 and beats=4; FSM in BURST for 3 cycles; pops on index 0 return A0..A3; pb_last is set on A3; busy[0] clears.
- Fill all 4 lists with 1-beat puts and pop none → 5th data beat sees a_ready=0, while a Get is still accepted. Pop list 2 → next cycle a put allocates put=2.
- Opcode 5, param=1, invalidate_ready=0, flush_ready=1 → a_ready=0 and req_valid=0. Raise invalidate_ready → accepted in the same cycle.
- Pop attempted in the cycle its beat is written → pb_pop_ready=0; asserted in the next cycle.
- rst pulsed mid-burst after 2 of 4 beats → empty=1, FSM=IDLE, next put allocates list 0.
